arbiter_rr_n: RTL and testbench
===============================

Name: arbiter_rr_n

Overview:
- Parametrised N-channel round-robin arbiter between the pixel-processing slave channels and the shared output FIFO of the image-processing accelerator.
- Grants one channel at a time and holds the grant for a burst.
- Muxes the granted channel's mode, data, proc value and valid onto the FIFO-side slvx_* bus.
- Honours FIFO back-pressure and master-0 completion, with fair rotation and a bounded burst length.

Parameters:
NCH, 2, number of slave channels (2..16)
DW, 32, data width per channel
PW, 8, proc-value width per channel
MAX_BURST, 64, beats per grant before forced rotation; 0 = unlimited
SW, (NCH>1 ? $clog2(NCH) : 1), channel index width (derived, not overridden)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
slv_mode  in  NCH*2  per-channel mode; 2'b00 = no request
slv_data  in  NCH*DW  per-channel data
slv_data_valid  in  NCH  per-channel data valid
slv_proc_val  in  NCH*PW  per-channel proc value
slv_ready  out  NCH  per-channel ready; one-hot or zero
fifo_full  in  1  FIFO full; no push while high
mstr0_cmplt  in  1  master-0 completion, level
slvx_mode  out  2  latched mode of granted channel
slvx_data  out  DW  muxed data
slvx_data_valid  out  1  FIFO push strobe
slvx_proc_val  out  PW  muxed proc value
data_source  out  SW  index of granted or last-granted channel
busy  out  1  high in GRANT state

Behaviour:
- Reset: all outputs 0. State IDLE, rr pointer 0, beat counter 0. While rst is high, slv_ready and slvx_data_valid are forced to 0 combinationally. Reset mid-burst drops the grant with no further push.
- Request: req[i] = (slv_mode[i] != 2'b00).
- FSM states: IDLE, GRANT, CMPLT_WAIT.
- IDLE, no request or mstr0_cmplt=1: stay in IDLE.
- IDLE, any req and mstr0_cmplt=0:
  - Pick the first requesting channel starting at ptr+1 (mod NCH), wrapping.
  - Register grant index into data_source; latch its mode into slvx_mode.
  - Clear the beat counter; go to GRANT. Arbitration latency is 1 cycle.
- GRANT:
  - slv_ready[g] = !fifo_full && !mstr0_cmplt && (slv_mode[g] == latched mode). All other ready bits are 0.
  - A beat transfers when slv_ready[g] && slv_data_valid[g].
  - slvx_data_valid equals the beat condition, with zero latency (combinational).
  - slvx_data and slvx_proc_val carry channel g's values on a beat and are 0 otherwise.
- GRANT release, with priority order:
  - (1) mstr0_cmplt=1 -> CMPLT_WAIT.
  - (2) slv_mode[g] differs from the latched mode (including 00) -> IDLE, no transfer that cycle.
  - (3) Beat with counter == MAX_BURST-1 (MAX_BURST != 0) -> IDLE after that beat.
  - On any release, ptr <= g.
- fifo_full in GRANT: hold the grant and hold the counter; no push. The FIFO's full must already cover the current cycle's push.
- CMPLT_WAIT: all ready bits 0, slvx_mode 0. Return to IDLE on the first cycle with mstr0_cmplt=0.
- Outside GRANT: slvx_mode=0, slvx_data=0, slvx_proc_val=0. data_source holds its last value.
- Fairness: a continuously requesting channel waits at most (NCH-1) bursts plus NCH dead cycles.
- Beat counter width: $clog2(MAX_BURST+1). It wraps harmlessly when MAX_BURST=0.

Decomposition:
- arb_pkg holds:
  - state enum arb_state_e {IDLE, GRANT, CMPLT_WAIT}
  - MODE_IDLE = 2'b00
  - mode typedef mode_t = logic [1:0]
- One combinational sub-module, rr_pick: inputs req[NCH] and ptr[SW]; outputs found and idx[SW] (rotate, priority-encode, un-rotate). It is instantiated once in the top.

Test Plan:
- NCH=2; ch0 mode=01 with continuous valid, ch1 idle -> grant ch0 in cycle 2 after request; one push per cycle with data passthrough; data_source=0.
- Both channels requesting, MAX_BURST=4 -> push pattern 4x ch0, 1 dead cycle, 4x ch1, dead cycle, 4x ch0; data_source toggles 0,1,0.
- fifo_full high for 3 cycles mid-burst on ch1 -> slv_ready=0 and slvx_data_valid=0 for exactly 3 cycles; burst resumes with counter unchanged; no beat lost or duplicated.
- mstr0_cmplt pulses high for 2 cycles during a ch0 burst -> ready drops the same cycle; state enters CMPLT_WAIT; next grant goes to ch1 (ptr=0) one cycle after cmplt falls.
- Granted channel's mode changes 01->10 mid-burst -> no transfer that cycle; back to IDLE; re-arbitration latches slvx_mode=10.
- rst asserted mid-burst for 1 cycle -> all outputs 0 the following cycle; next grant goes to ch1 (ptr reset to 0 gives search order 1,0).

Source files
------------

// File: rtl/arb_pkg.sv
// ---------------------------------------------------------------------------
// arb_pkg
// Shared types for the round-robin output arbiter of the pixel pipeline.
//   arb_state_e : arbiter FSM states
//   mode_t      : 2-bit channel mode; MODE_IDLE means "no request"
// ---------------------------------------------------------------------------
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        GRANT      = 2'd1,
        CMPLT_WAIT = 2'd2
    } arb_state_e;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_IDLE = 2'b00;

endpackage : arb_pkg

// File: rtl/rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Round-robin pick: first requesting channel at or after ptr+1 (mod NCH).
// Rotates the request vector so the search starts at bit 0, takes the
// lowest set bit, then maps the position back to a channel index.
//   req   in  NCH  request per channel
//   ptr   in  SW   last granted channel
//   found out 1    at least one request present
//   idx   out SW   chosen channel (0 when nothing found)
// ---------------------------------------------------------------------------
module rr_pick #(
    parameter int NCH = 2,
    parameter int SW  = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic [NCH-1:0] req,
    input  logic [SW-1:0]  ptr,
    output logic           found,
    output logic [SW-1:0]  idx
);

    logic [2*NCH-1:0] req_dbl;
    logic [NCH-1:0]   req_rot;
    int               start;

    // NOTE: every output of a combinational block gets a default before any
    // conditional assignment, otherwise synthesis infers a latch.
    always_comb begin
        start   = (int'(ptr) + 1) % NCH;
        req_dbl = {req, req};
        req_rot = NCH'(req_dbl >> start);
        found   = 1'b0;
        idx     = '0;
        // Descending scan: the lowest rotated position is written last and wins.
        for (int k = NCH - 1; k >= 0; k--) begin
            if (req_rot[k]) begin
                found = 1'b1;
                idx   = SW'((start + k) % NCH);
            end
        end
    end

endmodule : rr_pick

// File: rtl/arbiter_rr_n.sv
// ---------------------------------------------------------------------------
// arbiter_rr_n
// N-channel round-robin arbiter between the pixel slave channels and the
// shared output FIFO. One channel is granted per burst; its mode, data,
// proc value and valid are muxed onto the slvx_* bus.
//   clk, rst         clock, synchronous active-high reset
//   slv_mode         NCH x 2  per-channel mode, 00 = no request
//   slv_data         NCH x DW per-channel data
//   slv_data_valid   NCH      per-channel valid
//   slv_proc_val     NCH x PW per-channel proc value
//   slv_ready        NCH      ready to the granted channel only
//   fifo_full        FIFO full, blocks pushes
//   mstr0_cmplt      master-0 completion level, suspends arbitration
//   slvx_mode        latched mode of the granted channel (0 outside GRANT)
//   slvx_data        muxed data (0 when no push)
//   slvx_data_valid  FIFO push strobe
//   slvx_proc_val    muxed proc value (0 when no push)
//   data_source      granted / last-granted channel index
//   busy             high in GRANT
// ---------------------------------------------------------------------------
module arbiter_rr_n
    import arb_pkg::*;
#(
    parameter int  NCH       = 2,
    parameter int  DW        = 32,
    parameter int  PW        = 8,
    parameter int  MAX_BURST = 64,
    localparam int SW        = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NCH*2-1:0]  slv_mode,
    input  logic [NCH*DW-1:0] slv_data,
    input  logic [NCH-1:0]    slv_data_valid,
    input  logic [NCH*PW-1:0] slv_proc_val,
    output logic [NCH-1:0]    slv_ready,
    input  logic              fifo_full,
    input  logic              mstr0_cmplt,
    output logic [1:0]        slvx_mode,
    output logic [DW-1:0]     slvx_data,
    output logic              slvx_data_valid,
    output logic [PW-1:0]     slvx_proc_val,
    output logic [SW-1:0]     data_source,
    output logic              busy
);

    localparam int             CW        = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1;
    localparam logic [CW-1:0]  LAST_BEAT = CW'((MAX_BURST > 0) ? MAX_BURST - 1 : 0);

    arb_state_e      state_q, state_d;
    logic [SW-1:0]   ptr_q, ptr_d;
    logic [SW-1:0]   gnt_q, gnt_d;
    mode_t           mode_q, mode_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic [NCH-1:0]  req;
    logic            pick_found;
    logic [SW-1:0]   pick_idx;
    mode_t           pick_mode;
    mode_t           g_mode;
    logic            g_valid;
    logic [DW-1:0]   g_data;
    logic [PW-1:0]   g_proc;
    logic            in_grant;
    logic            mode_match;
    logic            ready_g;
    logic            beat;
    logic            last_beat;

    // Per-channel request decode and mux of the currently granted channel.
    always_comb begin
        req     = '0;
        g_mode  = MODE_IDLE;
        g_valid = 1'b0;
        g_data  = '0;
        g_proc  = '0;
        for (int i = 0; i < NCH; i++) begin
            req[i] = (slv_mode[2*i +: 2] != MODE_IDLE);
            if (SW'(i) == gnt_q) begin
                g_mode  = slv_mode[2*i +: 2];
                g_valid = slv_data_valid[i];
                g_data  = slv_data[DW*i +: DW];
                g_proc  = slv_proc_val[PW*i +: PW];
            end
        end
    end

    rr_pick #(.NCH(NCH), .SW(SW)) u_pick (
        .req   (req),
        .ptr   (ptr_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // Kept apart from the request decode so req -> pick -> mode is not a
    // loop through one block.
    always_comb begin
        pick_mode = MODE_IDLE;
        for (int i = 0; i < NCH; i++) begin
            if (SW'(i) == pick_idx) pick_mode = slv_mode[2*i +: 2];
        end
    end

    assign in_grant   = (state_q == GRANT);
    assign mode_match = (g_mode == mode_q);
    // Reset gates the handshake directly so nothing is pushed in the reset cycle.
    assign ready_g    = in_grant && !rst && !fifo_full && !mstr0_cmplt && mode_match;
    assign beat       = ready_g && g_valid;
    assign last_beat  = (MAX_BURST != 0) && (cnt_q == LAST_BEAT);

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            gnt_q   <= '0;
            mode_q  <= MODE_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        mode_d  = mode_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (pick_found && !mstr0_cmplt) begin
                    gnt_d   = pick_idx;
                    mode_d  = pick_mode;
                    cnt_d   = '0;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (mstr0_cmplt) begin
                    state_d = CMPLT_WAIT;
                    ptr_d   = gnt_q;
                end else if (!mode_match) begin
                    state_d = IDLE;
                    ptr_d   = gnt_q;
                end else if (beat) begin
                    // Counter only moves on a real transfer, so fifo_full holds it.
                    cnt_d = cnt_q + 1'b1;
                    if (last_beat) begin
                        state_d = IDLE;
                        ptr_d   = gnt_q;
                    end
                end
            end
            CMPLT_WAIT: begin
                if (!mstr0_cmplt) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs.
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            slv_ready[i] = ready_g && (SW'(i) == gnt_q);
        end
        slvx_data_valid = beat;
        slvx_data       = beat ? g_data : '0;
        slvx_proc_val   = beat ? g_proc : '0;
        slvx_mode       = in_grant ? mode_q : MODE_IDLE;
        data_source     = gnt_q;
        busy            = in_grant;
    end

endmodule : arbiter_rr_n

// File: tb/tb_arbiter_rr_n.sv
// ---------------------------------------------------------------------------
// tb_arbiter_rr_n
// Directed bench for arbiter_rr_n with NCH=2, MAX_BURST=4. Each channel is a
// source whose data is base + sequence number; the sequence advances after
// every accepted beat, so lost or duplicated beats show up as wrong data.
// Inputs change 1 ns after the rising edge, outputs are sampled on the
// falling edge.
// ---------------------------------------------------------------------------
module tb_arbiter_rr_n;

    localparam int NCH = 2;
    localparam int DW  = 32;
    localparam int PW  = 8;
    localparam int MB  = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    mode0, mode1;
    logic          v0, v1, full, cmplt;
    logic [31:0]   seq0, seq1;

    logic [NCH*2-1:0]  slv_mode;
    logic [NCH*DW-1:0] slv_data;
    logic [NCH-1:0]    slv_data_valid;
    logic [NCH*PW-1:0] slv_proc_val;
    logic [NCH-1:0]    slv_ready;
    logic [1:0]        slvx_mode;
    logic [DW-1:0]     slvx_data;
    logic              slvx_data_valid;
    logic [PW-1:0]     slvx_proc_val;
    logic              data_source;
    logic              busy;

    logic [1:0]  o_ready, o_mode;
    logic        o_valid, o_src, o_busy;
    logic [31:0] o_data;
    logic [7:0]  o_proc;

    int total = 0;
    int bad   = 0;

    assign slv_mode       = {mode1, mode0};
    assign slv_data       = {32'hB000_0000 + seq1, 32'hA000_0000 + seq0};
    assign slv_data_valid = {v1, v0};
    assign slv_proc_val   = {8'h80 + seq1[7:0], 8'h40 + seq0[7:0]};

    arbiter_rr_n #(.NCH(NCH), .DW(DW), .PW(PW), .MAX_BURST(MB)) dut (
        .clk             (clk),
        .rst             (rst),
        .slv_mode        (slv_mode),
        .slv_data        (slv_data),
        .slv_data_valid  (slv_data_valid),
        .slv_proc_val    (slv_proc_val),
        .slv_ready       (slv_ready),
        .fifo_full       (full),
        .mstr0_cmplt     (cmplt),
        .slvx_mode       (slvx_mode),
        .slvx_data       (slvx_data),
        .slvx_data_valid (slvx_data_valid),
        .slvx_proc_val   (slvx_proc_val),
        .data_source     (data_source),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    // One clock cycle: sample at the falling edge, let the sources advance
    // on an accepted beat, then step past the rising edge.
    task automatic run_cycle();
        @(negedge clk);
        o_ready = slv_ready;
        o_valid = slvx_data_valid;
        o_data  = slvx_data;
        o_proc  = slvx_proc_val;
        o_mode  = slvx_mode;
        o_src   = data_source;
        o_busy  = busy;
        @(posedge clk);
        if (o_ready[0] && v0) seq0 = seq0 + 1;
        if (o_ready[1] && v1) seq1 = seq1 + 1;
        #1;
    endtask

    task automatic go_idle();
        mode0 = 2'b00; mode1 = 2'b00; v0 = 1'b0; v1 = 1'b0;
        full = 1'b0; cmplt = 1'b0;
        repeat (3) run_cycle();
    endtask

    task automatic test_reset();
        rst = 1'b1; mode0 = 2'b01; v0 = 1'b1;
        run_cycle();
        run_cycle();
        total++; if (o_ready !== 2'b00) begin bad++; $display("FAIL reset_ready: got %b want 00", o_ready); end
        total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", o_valid); end
        total++; if (o_data !== 32'h0) begin bad++; $display("FAIL reset_data: got %h want 0", o_data); end
        total++; if (o_mode !== 2'b00) begin bad++; $display("FAIL reset_mode: got %b want 00", o_mode); end
        total++; if (o_src !== 1'b0) begin bad++; $display("FAIL reset_src: got %b want 0", o_src); end
        total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", o_busy); end
        mode0 = 2'b00; v0 = 1'b0;
        run_cycle();
        rst = 1'b0;
        run_cycle();
    endtask

    // ch0 alone: grant in the second cycle, 4-beat bursts with a dead cycle.
    task automatic test_single();
        bit          exp_v   [7] = '{0, 1, 1, 1, 1, 0, 1};
        int          exp_off [7] = '{0, 0, 1, 2, 3, 0, 4};
        logic [31:0] s = seq0;
        logic [31:0] e;
        mode0 = 2'b01; v0 = 1'b1;
        for (int k = 0; k < 7; k++) begin
            run_cycle();
            total++; if (o_valid !== exp_v[k]) begin bad++; $display("FAIL single_valid[%0d]: got %b want %b", k, o_valid, exp_v[k]); end
            if (exp_v[k]) begin
                e = 32'hA000_0000 + s + 32'(exp_off[k]);
                total++; if (o_data !== e) begin bad++; $display("FAIL single_data[%0d]: got %h want %h", k, o_data, e); end
                total++; if (o_proc !== 8'h40 + e[7:0]) begin bad++; $display("FAIL single_proc[%0d]: got %h want %h", k, o_proc, 8'h40 + e[7:0]); end
                total++; if (o_src !== 1'b0) begin bad++; $display("FAIL single_src[%0d]: got %b want 0", k, o_src); end
                total++; if (o_mode !== 2'b01) begin bad++; $display("FAIL single_mode[%0d]: got %b want 01", k, o_mode); end
            end
        end
        go_idle();
    endtask

    // Both channels requesting with ptr=1: ch0, dead, ch1, dead, ch0.
    task automatic test_rotation();
        bit          exp_v   [15] = '{0,1,1,1,1,0,1,1,1,1,0,1,1,1,1};
        bit          exp_src [15] = '{1,0,0,0,0,0,1,1,1,1,1,0,0,0,0};
        int          exp_off [15] = '{0,0,1,2,3,0,0,1,2,3,0,4,5,6,7};
        logic [31:0] s0, s1, e;
        // Leave ptr at 1 by granting ch1 briefly without transfers.
        mode1 = 2'b01; v1 = 1'b0;
        run_cycle(); run_cycle();
        mode1 = 2'b00;
        run_cycle(); run_cycle();
        s0 = seq0; s1 = seq1;
        mode0 = 2'b01; v0 = 1'b1; mode1 = 2'b01; v1 = 1'b1;
        for (int k = 0; k < 15; k++) begin
            run_cycle();
            total++; if (o_valid !== exp_v[k]) begin bad++; $display("FAIL rot_valid[%0d]: got %b want %b", k, o_valid, exp_v[k]); end
            total++; if (o_src !== exp_src[k]) begin bad++; $display("FAIL rot_src[%0d]: got %b want %b", k, o_src, exp_src[k]); end
            if (exp_v[k]) begin
                e = exp_src[k] ? 32'hB000_0000 + s1 + 32'(exp_off[k])
                               : 32'hA000_0000 + s0 + 32'(exp_off[k]);
                total++; if (o_data !== e) begin bad++; $display("FAIL rot_data[%0d]: got %h want %h", k, o_data, e); end
            end
        end
        go_idle();
    endtask

    // fifo_full for 3 cycles mid-burst on ch1 stalls without losing beats.
    task automatic test_fifo_full();
        bit          full_t  [9] = '{0,0,0,1,1,1,0,0,0};
        bit          exp_v   [9] = '{0,1,1,0,0,0,1,1,0};
        bit          exp_b   [9] = '{0,1,1,1,1,1,1,1,0};
        int          exp_off [9] = '{0,0,1,0,0,0,2,3,0};
        logic [31:0] s1 = seq1;
        logic [31:0] e;
        logic [1:0]  er;
        mode1 = 2'b01; v1 = 1'b1;
        for (int k = 0; k < 9; k++) begin
            full = full_t[k];
            run_cycle();
            er = exp_v[k] ? 2'b10 : 2'b00;
            total++; if (o_ready !== er) begin bad++; $display("FAIL full_ready[%0d]: got %b want %b", k, o_ready, er); end
            total++; if (o_valid !== exp_v[k]) begin bad++; $display("FAIL full_valid[%0d]: got %b want %b", k, o_valid, exp_v[k]); end
            total++; if (o_busy !== exp_b[k]) begin bad++; $display("FAIL full_busy[%0d]: got %b want %b", k, o_busy, exp_b[k]); end
            if (exp_v[k]) begin
                e = 32'hB000_0000 + s1 + 32'(exp_off[k]);
                total++; if (o_data !== e) begin bad++; $display("FAIL full_data[%0d]: got %h want %h", k, o_data, e); end
            end
        end
        go_idle();
    endtask

    // mstr0_cmplt for 2 cycles during a ch0 burst; next grant goes to ch1.
    task automatic test_cmplt();
        bit         cm_t   [8] = '{0,0,0,1,1,0,0,0};
        bit         r1_t   [8] = '{0,0,0,1,1,1,1,1};
        bit         exp_v  [8] = '{0,1,1,0,0,0,0,1};
        bit         exp_b  [8] = '{0,1,1,1,0,0,0,1};
        logic [1:0] exp_r  [8] = '{2'b00,2'b01,2'b01,2'b00,2'b00,2'b00,2'b00,2'b10};
        logic [1:0] exp_m  [8] = '{2'b00,2'b01,2'b01,2'b01,2'b00,2'b00,2'b00,2'b01};
        logic [31:0] s1;
        mode0 = 2'b01; v0 = 1'b1;
        for (int k = 0; k < 8; k++) begin
            cmplt = cm_t[k];
            mode1 = r1_t[k] ? 2'b01 : 2'b00;
            v1    = r1_t[k];
            s1    = seq1;
            run_cycle();
            total++; if (o_ready !== exp_r[k]) begin bad++; $display("FAIL cmplt_ready[%0d]: got %b want %b", k, o_ready, exp_r[k]); end
            total++; if (o_valid !== exp_v[k]) begin bad++; $display("FAIL cmplt_valid[%0d]: got %b want %b", k, o_valid, exp_v[k]); end
            total++; if (o_busy !== exp_b[k]) begin bad++; $display("FAIL cmplt_busy[%0d]: got %b want %b", k, o_busy, exp_b[k]); end
            total++; if (o_mode !== exp_m[k]) begin bad++; $display("FAIL cmplt_mode[%0d]: got %b want %b", k, o_mode, exp_m[k]); end
        end
        total++; if (o_src !== 1'b1) begin bad++; $display("FAIL cmplt_src: got %b want 1", o_src); end
        total++; if (o_data !== 32'hB000_0000 + s1) begin bad++; $display("FAIL cmplt_data: got %h want %h", o_data, 32'hB000_0000 + s1); end
        go_idle();
    endtask

    // Granted mode changes 01 -> 10: no transfer, release, re-grant with 10.
    task automatic test_mode_change();
        logic [1:0]  m_t   [5] = '{2'b01,2'b01,2'b10,2'b10,2'b10};
        bit          exp_v [5] = '{0,1,0,0,1};
        logic [1:0]  exp_m [5] = '{2'b00,2'b01,2'b01,2'b00,2'b10};
        int          off   [5] = '{0,0,0,0,1};
        logic [31:0] s0 = seq0;
        logic [31:0] e;
        v0 = 1'b1;
        for (int k = 0; k < 5; k++) begin
            mode0 = m_t[k];
            run_cycle();
            total++; if (o_valid !== exp_v[k]) begin bad++; $display("FAIL mode_valid[%0d]: got %b want %b", k, o_valid, exp_v[k]); end
            total++; if (o_mode !== exp_m[k]) begin bad++; $display("FAIL mode_mode[%0d]: got %b want %b", k, o_mode, exp_m[k]); end
            if (exp_v[k]) begin
                e = 32'hA000_0000 + s0 + 32'(off[k]);
                total++; if (o_data !== e) begin bad++; $display("FAIL mode_data[%0d]: got %h want %h", k, o_data, e); end
            end
        end
        total++; if (o_ready !== 2'b01) begin bad++; $display("FAIL mode_ready: got %b want 01", o_ready); end
        go_idle();
    endtask

    // One-cycle reset mid-burst: no push, outputs cleared, next grant ch1.
    task automatic test_reset_mid();
        logic [31:0] s1;
        mode0 = 2'b01; v0 = 1'b1;
        run_cycle();
        run_cycle();
        total++; if (o_valid !== 1'b1) begin bad++; $display("FAIL rmid_pre_valid: got %b want 1", o_valid); end
        mode1 = 2'b01; v1 = 1'b1; rst = 1'b1;
        s1 = seq1;
        run_cycle();
        total++; if (o_ready !== 2'b00) begin bad++; $display("FAIL rmid_rst_ready: got %b want 00", o_ready); end
        total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL rmid_rst_valid: got %b want 0", o_valid); end
        total++; if (o_data !== 32'h0) begin bad++; $display("FAIL rmid_rst_data: got %h want 0", o_data); end
        rst = 1'b0;
        run_cycle();
        total++; if (o_ready !== 2'b00) begin bad++; $display("FAIL rmid_ready: got %b want 00", o_ready); end
        total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL rmid_valid: got %b want 0", o_valid); end
        total++; if (o_mode !== 2'b00) begin bad++; $display("FAIL rmid_mode: got %b want 00", o_mode); end
        total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL rmid_busy: got %b want 0", o_busy); end
        total++; if (o_src !== 1'b0) begin bad++; $display("FAIL rmid_src: got %b want 0", o_src); end
        total++; if (o_proc !== 8'h00) begin bad++; $display("FAIL rmid_proc: got %h want 00", o_proc); end
        run_cycle();
        total++; if (o_src !== 1'b1) begin bad++; $display("FAIL rmid_next_src: got %b want 1", o_src); end
        total++; if (o_ready !== 2'b10) begin bad++; $display("FAIL rmid_next_ready: got %b want 10", o_ready); end
        total++; if (o_data !== 32'hB000_0000 + s1) begin bad++; $display("FAIL rmid_next_data: got %h want %h", o_data, 32'hB000_0000 + s1); end
        go_idle();
    endtask

    initial begin
        rst = 1'b1; mode0 = 2'b00; mode1 = 2'b00;
        v0 = 1'b0; v1 = 1'b0; full = 1'b0; cmplt = 1'b0;
        seq0 = 32'd0; seq1 = 32'd0;
        test_reset();
        test_single();
        test_rotation();
        test_fifo_full();
        test_cmplt();
        test_mode_change();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_arbiter_rr_n
